// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer_dev countdown timer: FSM state encoding,
// register word offsets, CTRL register layout and MODE decoding.
package timer_dev_pkg;

    // Countdown FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Register word offsets (addr_in[3:2])
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESET   = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    // MODE code for auto-reload; every other code (00 and reserved 1x) is one-shot
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    // CTRL layout: [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_dev_prescale.sv
// Tick generator for the timer: one tick every (prescale + 1) cycles while run
// is high. Restart returns the divider to zero so every countdown starts with a
// full prescale period. Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_dev_prescale #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_cnt;

    // >= rather than == so a PRESCALE lowered mid-count cannot leave the divider stranded
    assign tick = (div_cnt >= prescale);

    // Divider counter: cleared on reset/restart, wraps to zero on each tick
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the processor bus (DEV0).
// Registers (word offsets): 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only),
// 0xC PRESCALE only when the TIMER_PRESCALE_EN macro is defined.
// BASE_ADDR is assumed 16-byte aligned so addr_in[3:2] selects the register.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_in,
    input  logic        we,
    input  logic [3:0]  data_type,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] SPAN = 32'd15;
`else
    localparam logic [31:0] SPAN = 32'd11;
`endif

    state_t                state;
    state_t                next_state;
    ctrl_t                 ctrl;
    logic [31:0]           preset;
    logic [31:0]           count;
    logic                  irq_flag;
    logic [PRESCALE_W-1:0] prescale_val;
    logic                  tick;

    logic                  sel;
    logic [1:0]            reg_idx;
    logic                  wr_ok;
    logic                  wr_ctrl;
    logic                  wr_preset;
    logic                  load_count;
    logic                  dec_count;
    logic                  zero_count;
    logic                  set_flag;
    logic                  clr_en;
    logic [31:0]           rd_mux;

    assign sel       = (addr_in >= BASE_ADDR) && (addr_in <= BASE_ADDR + SPAN);
    assign reg_idx   = addr_in[3:2];
    // Only full-word writes are accepted; sub-word stores are silently dropped
    assign wr_ok     = we && sel && (data_type == 4'b0000);
    assign wr_ctrl   = wr_ok && (reg_idx == REG_CTRL);
    assign wr_preset = wr_ok && (reg_idx == REG_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic wr_prescale;
    assign wr_prescale = wr_ok && (reg_idx == REG_PRESCALE);

    // PRESCALE register, software R/W
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_val <= '0;
        end else if (wr_prescale) begin
            prescale_val <= wd[PRESCALE_W-1:0];
        end
    end

    timer_dev_prescale #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale (
        .clk      (clk),
        .reset    (reset),
        .restart  (state == ST_LOAD),
        .run      (state == ST_CNT),
        .prescale (prescale_val),
        .tick     (tick)
    );
`else
    // No prescaler: COUNT steps every cycle; 0xC lies outside sel
    assign prescale_val = '0;
    assign tick         = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and register-update strobes
    always_comb begin
        next_state = state;
        load_count = 1'b0;
        dec_count  = 1'b0;
        zero_count = 1'b0;
        set_flag   = 1'b0;
        clr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl.en) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_count = 1'b1;
                next_state = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl.en) begin
                    next_state = ST_IDLE;
                end else if (tick) begin
                    if (count > 32'd1) begin
                        dec_count = 1'b1;
                    end else begin
                        // COUNT of 0 or 1 both expire, so PRESET=0 acts like PRESET=1
                        zero_count = 1'b1;
                        set_flag   = 1'b1;
                        next_state = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (is_reload(ctrl.mode)) begin
                    next_state = ST_LOAD;
                end else begin
                    clr_en     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // CTRL register: a bus write wins over the one-shot EN clear on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= ctrl_t'(wd[3:0]);
        end else if (clr_en) begin
            ctrl.en <= 1'b0;
        end
    end

    // PRESET register; a write during CNT only takes effect at the next LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= wd;
        end
    end

    // COUNT register, updated only by the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load_count) begin
            count <= preset;
        end else if (dec_count) begin
            count <= count - 32'd1;
        end else if (zero_count) begin
            count <= '0;
        end
    end

    // Interrupt flag: set on expiry, cleared by software writes to CTRL/PRESET
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            irq_flag <= 1'b0;
        end else if (set_flag) begin
            irq_flag <= 1'b1;
        end
    end

    // Read mux: side-effect free, zero when the address is outside the device
    always_comb begin
        rd_mux = '0;
        if (sel) begin
            case (reg_idx)
                REG_CTRL:     rd_mux = {28'b0, ctrl};
                REG_PRESET:   rd_mux = preset;
                REG_COUNT:    rd_mux = count;
                REG_PRESCALE: rd_mux = 32'(prescale_val);
                default:      rd_mux = '0;
            endcase
        end
    end

    assign rd  = reset ? 32'h0 : rd_mux;
    assign irq = ctrl.im & irq_flag & ~reset;

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev. Inputs are driven and outputs
// sampled around the falling clock edge, away from the active rising edge.
module tb_timer_dev;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_PSC    = 32'h0000_7F0C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_in;
    logic        we;
    logic [3:0]  data_type;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    int exp3 [5] = '{3, 2, 1, 0, 0};

    always #5 clk = ~clk;

    timer_dev dut (
        .clk       (clk),
        .reset     (reset),
        .addr_in   (addr_in),
        .we        (we),
        .data_type (data_type),
        .wd        (wd),
        .rd        (rd),
        .irq       (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus write; the write lands on the next rising edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] dt);
        addr_in   = a;
        wd        = d;
        data_type = dt;
        we        = 1'b1;
        @(negedge clk);
        we        = 1'b0;
        data_type = 4'b0000;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_in = a;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        check(tag, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        we        = 1'b0;
        addr_in   = '0;
        wd        = '0;
        data_type = 4'b0000;
        step(2);
        reset = 1'b0;

        // 1: reset state
        chk_reg("rst_ctrl", A_CTRL, 32'h0);
        chk_reg("rst_preset", A_PRESET, 32'h0);
        chk_reg("rst_count", A_COUNT, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // 2: one-shot with IM, PRESET=5; irq at e0+7
        wr(A_PRESET, 32'd5, 4'b0000);
        chk_reg("os_preset", A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9, 4'b0000);
        step(2);
        for (int k = 0; k < 6; k++) begin
            chk_reg($sformatf("os_count%0d", k), A_COUNT, 32'(5 - k));
            if (k == 4) chk_irq("os_irq_before", 1'b0);
            if (k == 5) chk_irq("os_irq_rise", 1'b1);
            step(1);
        end
        chk_reg("os_en_cleared", A_CTRL, 32'h8);
        step(3);
        chk_irq("os_irq_held", 1'b1);
        chk_reg("os_count_hold", A_COUNT, 32'h0);
        wr(A_PRESET, 32'd7, 4'b0000);
        chk_irq("os_irq_cleared", 1'b0);

        // 3: auto-reload, PRESET=3, period 5
        wr(A_PRESET, 32'd3, 4'b0000);
        wr(A_CTRL, 32'hB, 4'b0000);
        step(2);
        for (int k = 0; k < 11; k++) begin
            chk_reg($sformatf("ar_count%0d", k), A_COUNT, 32'(exp3[k % 5]));
            if (k == 2) chk_irq("ar_irq_before", 1'b0);
            if (k == 3 || k == 9) chk_irq($sformatf("ar_irq%0d", k), 1'b1);
            step(1);
        end
        wr(A_CTRL, 32'h0, 4'b0000);
        chk_irq("ar_irq_cleared", 1'b0);
        step(4);

        // 4: sub-word CTRL write ignored, word write stops the count
        wr(A_PRESET, 32'd6, 4'b0000);
        wr(A_CTRL, 32'h1, 4'b0000);
        step(4);
        chk_reg("sb_count4", A_COUNT, 32'd4);
        wr(A_CTRL, 32'h0, 4'b0001);
        chk_reg("sb_count3", A_COUNT, 32'd3);
        chk_reg("sb_ctrl_kept", A_CTRL, 32'h1);
        wr(A_CTRL, 32'h0, 4'b0000);
        chk_reg("stop_count2", A_COUNT, 32'd2);
        step(3);
        chk_reg("stop_frozen", A_COUNT, 32'd2);
        chk_reg("stop_ctrl", A_CTRL, 32'h0);

        // 5: IM=0 expiry, then CTRL=IM clears the hidden flag
        wr(A_PRESET, 32'd2, 4'b0000);
        wr(A_CTRL, 32'h1, 4'b0000);
        step(6);
        chk_reg("nim_count", A_COUNT, 32'h0);
        chk_reg("nim_ctrl", A_CTRL, 32'h0);
        chk_irq("nim_irq", 1'b0);
        wr(A_CTRL, 32'h8, 4'b0000);
        chk_reg("nim_ctrl_im", A_CTRL, 32'h8);
        chk_irq("nim_irq_after_im", 1'b0);

        // PRESET=0 behaves as PRESET=1: irq at e0+3
        wr(A_PRESET, 32'd0, 4'b0000);
        wr(A_CTRL, 32'h9, 4'b0000);
        step(2);
        chk_irq("p0_irq_before", 1'b0);
        step(1);
        chk_irq("p0_irq_rise", 1'b1);
        step(1);
        chk_reg("p0_en_cleared", A_CTRL, 32'h8);

        // CTRL write on the INT edge beats the one-shot EN clear
        wr(A_PRESET, 32'd1, 4'b0000);
        wr(A_CTRL, 32'h9, 4'b0000);
        step(3);
        chk_irq("race_irq_int", 1'b1);
        wr(A_CTRL, 32'h9, 4'b0000);
        chk_reg("race_en_kept", A_CTRL, 32'h9);
        chk_irq("race_irq_cleared", 1'b0);
        step(3);
        chk_irq("race_rearm_irq", 1'b1);
        wr(A_CTRL, 32'h0, 4'b0000);
        step(2);

        // Bus decode corner cases
        wr(A_COUNT, 32'h55, 4'b0000);
        chk_reg("count_ro", A_COUNT, 32'h0);
        wr(A_PRESET, 32'h1234, 4'b0011);
        chk_reg("preset_subword", A_PRESET, 32'd1);
        chk_reg("below_base", 32'h0000_7EFC, 32'h0);
        chk_reg("above_range", 32'h0000_7F10, 32'h0);
`ifndef TIMER_PRESCALE_EN
        wr(A_PSC, 32'h2, 4'b0000);
        chk_reg("psc_absent", A_PSC, 32'h0);
`endif

        // 6: reset mid-count
        wr(A_PRESET, 32'd5, 4'b0000);
        wr(A_CTRL, 32'h9, 4'b0000);
        step(4);
        chk_reg("mid_count3", A_COUNT, 32'd3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_reg("mid_rst_ctrl", A_CTRL, 32'h0);
        chk_reg("mid_rst_preset", A_PRESET, 32'h0);
        chk_reg("mid_rst_count", A_COUNT, 32'h0);
        chk_irq("mid_rst_irq", 1'b0);
        step(3);
        chk_reg("mid_rst_idle", A_COUNT, 32'h0);

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=2: COUNT steps every 3 cycles
        chk_reg("psc_rst", A_PSC, 32'h0);
        wr(A_PSC, 32'h2, 4'b0000);
        chk_reg("psc_rw", A_PSC, 32'h2);
        wr(A_PRESET, 32'd3, 4'b0000);
        wr(A_CTRL, 32'h1, 4'b0000);
        step(2);
        chk_reg("psc_c3a", A_COUNT, 32'd3);
        step(2);
        chk_reg("psc_c3b", A_COUNT, 32'd3);
        step(1);
        chk_reg("psc_c2a", A_COUNT, 32'd2);
        step(2);
        chk_reg("psc_c2b", A_COUNT, 32'd2);
        step(1);
        chk_reg("psc_c1", A_COUNT, 32'd1);
        wr(A_CTRL, 32'h0, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
